// File: rtl/imm_arb_pkg.sv
// Shared types and helpers for the immediate-extension arbiter.
// The optional per-request zero-extension is selected in the top by IMMARB_ZEXT_EN.
package imm_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

  // Widest immediate the extend helper handles; callers slice the low OUT_W bits.
  localparam int EXT_MAX_W = 32;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [EXT_MAX_W-1:0] extend_imm(
    input logic [EXT_MAX_W-1:0] imm,
    input int                   in_w,
    input int                   out_w,
    input logic                 sgn
  );
    logic [EXT_MAX_W-1:0] ext;
    logic                 fill;
    fill = 1'b0;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i == in_w - 1) fill = sgn & imm[i];
    end
    ext = '0;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i < in_w)       ext[i] = imm[i];
      else if (i < out_w) ext[i] = fill;
    end
    return ext;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr.
// The pointer register is owned by the parent.
module rr_arbiter
  import imm_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_any && (j == (int'(rr_ptr) + k) % NUM_REQ) && req_valid[j]) begin
          grant_any = 1'b1;
          grant_idx = ID_W'(j);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_any && (int'(grant_idx) == j)) grant[j] = 1'b1;
    end
  end

endmodule

// File: rtl/imm_extend_arbiter.sv
// Round-robin shared immediate sign/zero-extender with a valid/ready response.
// Define IMMARB_ZEXT_EN to honour req_signed per request; otherwise all requests sign-extend.
module imm_extend_arbiter
  import imm_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int IN_W    = 3,
  parameter  int OUT_W   = 8,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_imm,
  input  logic [NUM_REQ-1:0]      req_signed,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [OUT_W-1:0]        resp_data,
  output logic [ID_W-1:0]         resp_id
);

  arb_state_e         r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [OUT_W-1:0]   r_resp_data;
  logic [ID_W-1:0]    r_resp_id;

  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_grant_idx;
  logic                 w_grant_any;
  logic                 w_accept_en;
  logic                 w_accept;
  logic [IN_W-1:0]      w_imm;
  logic                 w_sgn_sel;
  logic                 w_sgn;
  logic [EXT_MAX_W-1:0] w_ext_full;
  logic                 w_unused_ext;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  // A held result may be replaced in the same cycle it is consumed.
  assign w_accept_en = (r_state == IDLE) || resp_ready;
  assign w_accept    = w_accept_en && w_grant_any;
  assign req_ready   = w_accept_en ? w_grant : '0;

  always_comb begin
    w_imm     = '0;
    w_sgn_sel = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (int'(w_grant_idx) == j) begin
        w_imm     = req_imm[j*IN_W +: IN_W];
        w_sgn_sel = req_signed[j];
      end
    end
  end

`ifdef IMMARB_ZEXT_EN
  assign w_sgn = w_sgn_sel;
`else
  logic w_unused_sgn;
  assign w_unused_sgn = w_sgn_sel;
  assign w_sgn        = 1'b1;
`endif

  assign w_ext_full   = extend_imm(EXT_MAX_W'(w_imm), IN_W, OUT_W, w_sgn);
  assign w_unused_ext = ^w_ext_full;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_resp_data <= '0;
      r_resp_id   <= '0;
    end else if (w_accept) begin
      r_state     <= RESP;
      r_resp_data <= w_ext_full[OUT_W-1:0];
      r_resp_id   <= w_grant_idx;
      r_rr_ptr    <= ID_W'((int'(w_grant_idx) + 1) % NUM_REQ);
    end else if ((r_state == RESP) && resp_ready) begin
      r_state <= IDLE;
    end
  end

  assign resp_valid = (r_state == RESP);
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// Directed plus randomized bench for imm_extend_arbiter against a behavioural model.
// Build with +define+IMMARB_ZEXT_EN to exercise per-request zero-extension.
module tb_imm_extend_arbiter;

  localparam int N    = 4;
  localparam int IN_W = 3;
  localparam int OUT_W = 8;
  localparam int IDW  = 2;

  logic              sysclk = 1'b0;
  logic              rst_n  = 1'b0;
  logic [N-1:0]      req_valid  = '0;
  logic [N-1:0]      req_signed = '0;
  logic [N*IN_W-1:0] req_imm    = '0;
  logic              resp_ready = 1'b0;
  logic [N-1:0]      req_ready;
  logic              resp_valid;
  logic [OUT_W-1:0]  resp_data;
  logic [IDW-1:0]    resp_id;

  imm_extend_arbiter #(.NUM_REQ(N), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_imm    (req_imm),
    .req_signed (req_signed),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;

  // reference model: holds at most one result, pointer to next-preferred requester
  bit m_valid;
  int m_data, m_id, m_ptr, m_grant;
  logic [N-1:0] pending;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_grant = -1;
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int ref_ext(input int imm, input bit sgn);
    int v;
    v = imm;
    if (sgn && imm >= (1 << (IN_W - 1))) v = imm - (1 << IN_W);
    return v & ((1 << OUT_W) - 1);
  endfunction

  task automatic set_req(input int i, input int imm, input bit sgn);
    req_imm[i*IN_W +: IN_W] = IN_W'(imm);
    req_signed[i] = sgn;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int g, imm;
    bit acc, sgn;
    @(negedge sysclk);
    g   = pick();
    acc = (!m_valid || resp_ready) && (g >= 0);
    chk("req_ready", 32'(req_ready), acc ? (1 << g) : 0);
    chk("resp_valid", 32'(resp_valid), 32'(m_valid));
    chk("resp_data", 32'(resp_data), m_data);
    chk("resp_id", 32'(resp_id), m_id);
    @(posedge sysclk);
    m_grant = acc ? g : -1;
    if (acc) begin
      imm = int'(req_imm >> (g * IN_W)) & ((1 << IN_W) - 1);
`ifdef IMMARB_ZEXT_EN
      sgn = req_signed[g];
`else
      sgn = 1'b1;
`endif
      m_data  = ref_ext(imm, sgn);
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && resp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    model_reset();
    #12;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    @(posedge sysclk); #1;
    rst_n = 1'b1;

    // single signed request from requester 1
    set_req(1, 3'b101, 1'b1);
    req_valid = 4'b0010;
    cycle();
    chk("single_valid", 32'(resp_valid), 1);
    chk("single_data", 32'(resp_data), 32'h0FD);
    chk("single_id", 32'(resp_id), 1);
    req_valid = '0; resp_ready = 1'b1;
    cycle();

    // requester 0, zero-extension requested
    set_req(0, 3'b101, 1'b0);
    req_valid = 4'b0001;
    cycle();
`ifdef IMMARB_ZEXT_EN
    chk("zext_data", 32'(resp_data), 32'h05);
`else
    chk("zext_data", 32'(resp_data), 32'hFD);
`endif
    req_valid = '0;
    cycle();

    // fairness: everyone requesting, consumer always ready
    start = m_ptr;
    for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 7), $urandom_range(0, 1));
    req_valid = '1;
    for (int i = 0; i < 2 * N; i++) begin
      cycle();
      chk("fair_valid", 32'(resp_valid), 1);
      chk("fair_id", 32'(resp_id), (start + i) % N);
    end
    req_valid = '0;
    cycle();

    // backpressure: hold requester 1's result while 2 and 3 wait
    resp_ready = 1'b0;
    set_req(1, 3'b011, 1'b1);
    req_valid = 4'b0010;
    cycle();
    set_req(2, 3'b110, 1'b1);
    set_req(3, 3'b001, 1'b0);
    req_valid = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_id", 32'(resp_id), 1);
      chk("bp_data", 32'(resp_data), 32'h03);
      chk("bp_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    cycle();
    chk("bp_release_id", 32'(resp_id), 2);
    req_valid = 4'b1000;
    cycle();
    req_valid = '0;
    cycle();

    // asynchronous reset while a result is held
    resp_ready = 1'b0;
    set_req(0, 3'b010, 1'b1);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(resp_valid), 0);
    model_reset();
    @(posedge sysclk); #1;
    rst_n = 1'b1;
    set_req(3, 3'b111, 1'b1);
    set_req(0, 3'b100, 1'b1);
    req_valid = 4'b1001;
    resp_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    cycle();
    chk("post_rst_id", 32'(resp_id), 0);
    req_valid = 4'b1000;
    cycle();

    // randomized traffic with protocol-respecting requesters
    pending = '0;
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (m_grant >= 0) pending[m_grant] = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (!pending[j] && $urandom_range(0, 1) == 1) begin
          pending[j] = 1'b1;
          set_req(j, $urandom_range(0, 7), $urandom_range(0, 1));
        end
      end
      req_valid  = pending;
      resp_ready = ($urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
